case_9_sdiv_8s_5s_seq: RTL and testbench

Sequential signed integer divider, the inverse operator to the team's `case_9` 5s×3s→8 multiply core. It takes an 8-bit signed dividend and a 5-bit signed divisor and returns a C-semantics quotient and remainder: truncation toward zero, with the remainder taking the sign of the dividend. It uses radix-2 restoring division, one quotient bit per clock, behind valid/ready handshakes on both sides. It sits in the datapath wherever HLS schedules a `/` or `%` that is too wide for a combinational core.

---
 rtl/case_9_sdiv_8s_5s_seq.sv | 149 ++++++++++++++
 tb/tb_case_9_sdiv_8s_5s_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/case_9_sdiv_8s_5s_seq.sv
// ---------------------------------------------------------------------------
// case_9_sdiv_8s_5s_seq
//
// Sequential signed divider: radix-2 restoring division, one quotient bit per
// clock. The quotient truncates toward zero and the remainder takes the sign
// of the dividend, matching C '/' and '%'. A zero divisor returns quot = -1,
// rem = 0 and raises div_by_zero.
//
// Ports:
//   ap_clk       clock, rising edge
//   ap_rst_n     asynchronous active-low reset
//   ce           clock enable; all state holds while low
//   in_valid     operands valid           in_ready   operands accepted (IDLE)
//   din0         signed dividend          din1       signed divisor
//   out_valid    result valid             out_ready  consumer takes result
//   quot         signed quotient          rem        signed remainder
//   div_by_zero  held result came from a zero divisor
// ---------------------------------------------------------------------------
module case_9_sdiv_8s_5s_seq #(
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 5
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [din0_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int CW = $clog2(W0 + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_reg;
  // The dividend register shifts out its MSB each step and shifts in the new
  // quotient bit at the bottom, so after W0 steps it holds |quotient|.
  logic [W0-1:0] dvd_reg;
  logic [W1-1:0] dvs_reg;
  logic [W1:0]   prem_reg;
  logic [CW-1:0] cnt_reg;
  logic          sign_q_reg;
  logic          sign_r_reg;
  logic          dbz_reg;

  logic [W1:0]   shift_next;
  logic [W1+1:0] diff_next;
  logic          q_bit;
  logic [W1:0]   prem_next;
  logic [W0-1:0] dvd_next;
  logic [W0-1:0] abs0;
  logic [W1-1:0] abs1;
  logic [W0-1:0] quot_next;
  logic [W1-1:0] rem_next;

  always_comb begin
    // The partial remainder is always below |divisor| (<= 2^(W1-1)), so its
    // low W1 bits are enough to form the shifted value.
    shift_next = {prem_reg[W1-1:0], dvd_reg[W0-1]};
    // One extra bit so the trial difference carries its own sign.
    diff_next  = {1'b0, shift_next} - {2'b00, dvs_reg};
    q_bit      = ~diff_next[W1+1];
    prem_next  = q_bit ? diff_next[W1:0] : shift_next;
    dvd_next   = {dvd_reg[W0-2:0], q_bit};

    // Magnitudes as unsigned values: the most negative input maps onto
    // 2^(W-1), which still fits the unsigned width.
    abs0 = din0[W0-1] ? -din0 : din0;
    abs1 = din1[W1-1] ? -din1 : din1;

    // Negation wraps, so -128 / -1 lands on 0x80 with no special case.
    quot_next = sign_q_reg ? -dvd_reg : dvd_reg;
    rem_next  = sign_r_reg ? -prem_reg[W1-1:0] : prem_reg[W1-1:0];
    if (dbz_reg) begin
      quot_next = '1;
      rem_next  = '0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg   <= IDLE;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      prem_reg    <= '0;
      cnt_reg     <= '0;
      sign_q_reg  <= 1'b0;
      sign_r_reg  <= 1'b0;
      dbz_reg     <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else if (ce) begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            dvd_reg    <= abs0;
            dvs_reg    <= abs1;
            prem_reg   <= '0;
            cnt_reg    <= CW'(W0);
            sign_q_reg <= din0[W0-1] ^ din1[W1-1];
            sign_r_reg <= din0[W0-1];
            dbz_reg    <= (din1 == '0);
            in_ready   <= 1'b0;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          // W0 restoring steps, then one more edge to load the output
          // registers with the sign-corrected result.
          if (cnt_reg != '0) begin
            prem_reg <= prem_next;
            dvd_reg  <= dvd_next;
            cnt_reg  <= cnt_reg - CW'(1);
          end else begin
            quot        <= quot_next;
            rem         <= rem_next;
            div_by_zero <= dbz_reg;
            out_valid   <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_case_9_sdiv_8s_5s_seq.sv
module tb_case_9_sdiv_8s_5s_seq;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n = 1'b0;
  logic       ce = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] din0 = 8'd0;
  logic [4:0] din1 = 5'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] quot;
  logic [4:0] rem;
  logic       div_by_zero;

  int total = 0;
  int bad = 0;

  case_9_sdiv_8s_5s_seq #(.din0_WIDTH(8), .din1_WIDTH(5)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  // Reference: C-semantics division via integer arithmetic (SV '/' and '%'
  // truncate toward zero, remainder follows the dividend).
  function automatic void model(input logic signed [7:0] a, input logic signed [4:0] b,
                                output logic [7:0] q, output logic [4:0] r, output logic z);
    int ai, bi, qi, ri;
    ai = a;
    bi = b;
    if (bi == 0) begin
      q = 8'hFF; r = 5'd0; z = 1'b1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      q = qi[7:0]; r = ri[4:0]; z = 1'b0;
    end
  endfunction

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  // One complete division. stall_at>0 drops ce for 3 edges after that many
  // post-accept edges; hold keeps out_ready low for 20 cycles of DONE.
  task automatic run_op(input logic signed [7:0] a, input logic signed [4:0] b,
                        input string tag, input int stall_at, input bit hold);
    logic [7:0] eq;
    logic [4:0] er;
    logic       ez;
    int         edges;
    int         exp_lat;
    model(a, b, eq, er, ez);
    exp_lat = (stall_at > 0) ? 12 : 9;
    edges = 0;
    while (!in_ready && edges < 40) begin tick; edges++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s in_ready got=%b want=1", tag, in_ready);
    end
    out_ready = hold ? 1'b0 : 1'b1;
    in_valid = 1'b1; din0 = a; din1 = b;
    tick;
    in_valid = 1'b0; din0 = 8'($urandom); din1 = 5'($urandom);
    edges = 0;
    while (!out_valid && edges < 60) begin
      tick;
      edges++;
      if (stall_at > 0 && edges == stall_at) ce = 1'b0;
      if (stall_at > 0 && edges == stall_at + 3) ce = 1'b1;
    end
    ce = 1'b1;
    total++;
    if (edges !== exp_lat) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", tag, edges, exp_lat);
    end
    total++;
    if ({quot, rem, div_by_zero} !== {eq, er, ez}) begin
      bad++; $display("FAIL %s result got q=%h r=%h z=%b want q=%h r=%h z=%b",
                      tag, quot, rem, div_by_zero, eq, er, ez);
    end
    if (hold) begin
      for (int i = 0; i < 20; i++) begin
        tick;
        total++;
        if ({out_valid, in_ready, quot, rem, div_by_zero} !== {1'b1, 1'b0, eq, er, ez}) begin
          bad++; $display("FAIL %s hold cyc %0d got v=%b rdy=%b q=%h r=%h z=%b", tag, i,
                          out_valid, in_ready, quot, rem, div_by_zero);
        end
      end
      out_ready = 1'b1;
    end
    tick;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL %s handshake got v=%b rdy=%b want v=0 rdy=1", tag, out_valid, in_ready);
    end
    $display("op %s: %0d / %0d -> q=%h r=%h z=%b lat=%0d", tag, a, b, quot, rem, div_by_zero, edges);
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0;
    repeat (3) tick;
    total++;
    if ({in_ready, out_valid, quot, rem, div_by_zero} !== {1'b1, 1'b0, 8'h00, 5'h00, 1'b0}) begin
      bad++; $display("FAIL reset got rdy=%b v=%b q=%h r=%h z=%b want rdy=1 v=0 q=00 r=00 z=0",
                      in_ready, out_valid, quot, rem, div_by_zero);
    end
    ap_rst_n = 1'b1;
    tick;
    $display("reset released");
  endtask

  task automatic test_directed;
    logic signed [7:0] ta [12] = '{8'sd100, -8'sd100, 8'sd100, -8'sd100, 8'sd5, -8'sd128,
                                   8'sd127, -8'sd128, 8'sd37, 8'sd37, -8'sd1, 8'sd0};
    logic signed [4:0] tb_ [12] = '{5'sd7, 5'sd7, -5'sd7, -5'sd7, -5'sd16, -5'sd1,
                                    5'sd1, -5'sd16, 5'sd0, 5'sd5, 5'sd15, -5'sd3};
    for (int i = 0; i < 12; i++) run_op(ta[i], tb_[i], $sformatf("dir%0d", i), 0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_op(-8'sd77, 5'sd6, "backpressure", 0, 1'b1);
  endtask

  task automatic test_ce_stall;
    run_op(8'sd100, 5'sd7, "ce_stall", 4, 1'b0);
  endtask

  task automatic test_async_reset;
    int edges;
    in_valid = 1'b1; din0 = 8'sd100; din1 = 5'sd7;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    #2;
    ap_rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, quot, rem, div_by_zero} !== {1'b1, 1'b0, 8'h00, 5'h00, 1'b0}) begin
      bad++; $display("FAIL async_reset got rdy=%b v=%b q=%h r=%h z=%b want rdy=1 v=0 q=00 r=00 z=0",
                      in_ready, out_valid, quot, rem, div_by_zero);
    end
    tick;
    ap_rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (out_valid) edges++;
    end
    total++;
    if (edges !== 0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL stale_result got valid_cycles=%0d rdy=%b want 0 and 1", edges, in_ready);
    end
    $display("async reset mid-calc done");
    run_op(8'sd50, 5'sd3, "after_reset", 0, 1'b0);
  endtask

  task automatic test_random;
    logic signed [7:0] a;
    logic signed [4:0] b;
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 5'sd0 : 5'($urandom);
      run_op(a, b, $sformatf("rnd%0d", i), 0, 1'b0);
    end
  endtask

  // in_valid held high throughout; operands change every cycle, so only the
  // values present on the accept edges may show up in the results.
  task automatic test_back_to_back;
    logic [7:0] qq [$];
    logic [4:0] rq [$];
    logic       zq [$];
    logic [7:0] eq;
    logic [4:0] er;
    logic       ez;
    int cyc = 0, accepted = 0, done = 0, last_acc = -1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    while (done < 6 && cyc < 200) begin
      if (in_ready && accepted < 6) begin
        din0 = 8'($urandom); din1 = 5'($urandom);
        model(din0, din1, eq, er, ez);
        qq.push_back(eq); rq.push_back(er); zq.push_back(ez);
        accepted++;
        if (last_acc >= 0) begin
          total++;
          if (cyc + 1 - last_acc !== 11) begin
            bad++; $display("FAIL b2b spacing got=%0d want=11", cyc + 1 - last_acc);
          end
        end
        last_acc = cyc + 1;
      end else begin
        in_valid = (accepted < 6);
        din0 = 8'($urandom); din1 = 5'($urandom);
      end
      tick;
      cyc++;
      if (out_valid && qq.size() > 0) begin
        eq = qq.pop_front(); er = rq.pop_front(); ez = zq.pop_front();
        total++;
        if ({quot, rem, div_by_zero} !== {eq, er, ez}) begin
          bad++; $display("FAIL b2b result %0d got q=%h r=%h z=%b want q=%h r=%h z=%b",
                          done, quot, rem, div_by_zero, eq, er, ez);
        end
        $display("b2b %0d: q=%h r=%h z=%b", done, quot, rem, div_by_zero);
        done++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (done !== 6) begin
      bad++; $display("FAIL b2b completed got=%0d want=6", done);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_ce_stall;
    test_async_reset;
    test_random;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
